// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generator feeding a 2-entry {instr, pc} queue toward decode.
// Optional macro FETCH_MISALIGN_CHK_EN turns misaligned redirects into a sticky fault.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     fault
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic [1:0]    r_count;
  logic          r_valid;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_instr0, r_instr1;
  logic [AW-1:0] r_pc0, r_pc1;

  logic [1:0]    w_count_n, w_base;
  logic [AW-1:0] w_pc_n;
  logic [DW-1:0] w_instr0_n, w_instr1_n;
  logic [AW-1:0] w_pc0_n, w_pc1_n;
  logic          w_pop, w_push, w_halt, w_fault_n;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;
  assign w_halt = r_fault;
  assign fault  = r_fault;
`else
  assign w_halt = 1'b0;
  assign fault  = 1'b0;
`endif

  // Next-state: redirect flushes; otherwise pop shifts the queue and push appends at the tail.
  always_comb begin
    w_pop      = r_valid && out_ready;
    w_push     = !redirect_valid && !w_halt && ((r_count != 2'd2) || w_pop);
    w_count_n  = r_count;
    w_base     = r_count;
    w_pc_n     = r_pc;
    w_instr0_n = r_instr0;
    w_instr1_n = r_instr1;
    w_pc0_n    = r_pc0;
    w_pc1_n    = r_pc1;
    w_fault_n  = w_halt;
    if (redirect_valid) begin
      w_count_n = 2'd0;
`ifdef FETCH_MISALIGN_CHK_EN
      w_pc_n    = redirect_pc;
      w_fault_n = (redirect_pc[1:0] != 2'b00);
`else
      w_pc_n    = {redirect_pc[AW-1:2], 2'b00};
`endif
    end else begin
      if (w_pop) begin
        w_instr0_n = r_instr1;
        w_pc0_n    = r_pc1;
      end
      w_base = r_count - {1'b0, w_pop};
      if (w_push) begin
        if (w_base == 2'd0) begin
          w_instr0_n = instr;
          w_pc0_n    = r_pc;
        end else begin
          w_instr1_n = instr;
          w_pc1_n    = r_pc;
        end
        w_pc_n = r_pc + AW'(4);
      end
      w_count_n = w_base + {1'b0, w_push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_valid  <= 1'b0;
      r_pc     <= RESET_PC;
      r_instr0 <= '0;
      r_instr1 <= '0;
      r_pc0    <= '0;
      r_pc1    <= '0;
    end else begin
      r_count  <= w_count_n;
      r_valid  <= (w_count_n != 2'd0);
      r_pc     <= w_pc_n;
      r_instr0 <= w_instr0_n;
      r_instr1 <= w_instr1_n;
      r_pc0    <= w_pc0_n;
      r_pc1    <= w_pc1_n;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else        r_fault <= w_fault_n;
  end
`else
  logic w_unused;
  assign w_unused = w_fault_n;
`endif

  assign pc        = r_pc;
  assign out_valid = r_valid;
  assign out_instr = r_instr0;
  assign out_pc    = r_pc0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, wrap, misalignment, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k.
  assign instr = 32'h1000_0000 + 32'(pc >> 2);

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000_0000 + 32'(a >> 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] exp_pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, 32'(out_pc), 32'(exp_pc));
    chk({tag, "_instr"}, out_instr, mem_word(exp_pc));
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);

    // Streaming at one per cycle from RESET_PC
    rst_n = 1'b1;
    tick(); chk_head("s0", 16'h0000); chk("s0_next_pc", 32'(pc), 32'h4);
    tick(); chk_head("s1", 16'h0004);
    tick(); chk_head("s2", 16'h0008);

    // Fresh start, then back-pressure right after the first valid output
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick(); chk_head("bp_first", 16'h0000);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("bp_hold", 16'h0000);
    chk("bp_pc_frozen", 32'(pc), 32'h8);
    out_ready = 1'b1;
    tick(); chk_head("bp_resume0", 16'h0004);
    tick(); chk_head("bp_resume1", 16'h0008);

    // Redirect while full with a pop in the same cycle
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    chk("rd_pc", 32'(pc), 32'h0100);
    redirect_valid = 1'b0;
    tick(); chk_head("rd_t0", 16'h0100);
    tick(); chk_head("rd_t1", 16'h0104);

    // Address wrap at the top of the space
    redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
    tick(); redirect_valid = 1'b0;
    tick(); chk_head("wr0", 16'hFFF8);
    tick(); chk_head("wr1", 16'hFFFC);
    tick(); chk_head("wr2", 16'h0000);
    tick(); chk_head("wr3", 16'h0004);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 16'h0102;
    tick(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    chk("mis_pc", 32'(pc), 32'h0102);
    tick(); tick();
    chk("mis_fault_sticky", 32'(fault), 32'd1);
    chk("mis_valid_stays0", 32'(out_valid), 32'd0);
    chk("mis_pc_held", 32'(pc), 32'h0102);
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick(); redirect_valid = 1'b0;
    chk("mis_clear", 32'(fault), 32'd0);
    chk("mis_clear_valid", 32'(out_valid), 32'd0);
    tick(); chk_head("mis_resume", 16'h0200);
`else
    chk("mis_fault", 32'(fault), 32'd0);
    chk("mis_pc", 32'(pc), 32'h0100);
    tick(); chk_head("mis_aligned", 16'h0100);
    chk("mis_fault_after", 32'(fault), 32'd0);
`endif

    // Mid-stream reset with a full queue
    out_ready = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'h0);
    chk("async_rst_fault", 32'(fault), 32'd0);
    #1; rst_n = 1'b1; out_ready = 1'b1;
    tick(); chk_head("rst_restart0", 16'h0000);
    tick(); chk_head("rst_restart1", 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
